// File: rtl/dmem_lsu.sv
// Load/store unit in front of a word-addressed data memory with RMW sub-word stores.
// Optional misalignment trapping is enabled by defining LSU_ALIGN_CHECK_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef DMEM_ADDR_WIDTH
`define DMEM_ADDR_WIDTH 10
`endif

module dmem_lsu #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = `DMEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] dmem_address,
    output logic [DATA_WIDTH-1:0] dmem_write_data,
    output logic                  dmem_write_enable,
    input  logic [DATA_WIDTH-1:0] dmem_read_data,
    input  logic                  dmem_read_data_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MERGE,
        S_WR,
        S_DONE
    } state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    state_e                state_q, state_d;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  err_q;
    logic [31:0]           buf_q, buf_d;

    logic                  hs;
    logic                  req_err;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           load_val;
    logic [31:0]           merge_val;

    assign hs = req_valid & req_ready;

    always_comb begin
        req_err = (req_size == 2'b11);
`ifdef LSU_ALIGN_CHECK_EN
        if (req_size == SZ_H && req_addr[0])
            req_err = 1'b1;
        if (req_size == SZ_W && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
`endif
    end

    // Lane select and sign/zero extension for loads.
    always_comb begin
        unique case (addr_q[1:0])
            2'd0:    rd_byte = dmem_read_data[7:0];
            2'd1:    rd_byte = dmem_read_data[15:8];
            2'd2:    rd_byte = dmem_read_data[23:16];
            default: rd_byte = dmem_read_data[31:24];
        endcase
        rd_half = addr_q[1] ? dmem_read_data[31:16]
                            : dmem_read_data[15:0];
        unique case (size_q)
            SZ_B:    load_val = {{24{~uns_q & rd_byte[7]}}, rd_byte};
            SZ_H:    load_val = {{16{~uns_q & rd_half[15]}}, rd_half};
            default: load_val = dmem_read_data[31:0];
        endcase
    end

    // Replace the addressed lane of the fetched word with store data.
    always_comb begin
        merge_val = dmem_read_data[31:0];
        unique case (size_q)
            SZ_B: begin
                unique case (addr_q[1:0])
                    2'd0:    merge_val[7:0]   = wdata_q[7:0];
                    2'd1:    merge_val[15:8]  = wdata_q[7:0];
                    2'd2:    merge_val[23:16] = wdata_q[7:0];
                    default: merge_val[31:24] = wdata_q[7:0];
                endcase
            end
            SZ_H: begin
                if (addr_q[1])
                    merge_val[31:16] = wdata_q[15:0];
                else
                    merge_val[15:0] = wdata_q[15:0];
            end
            default: merge_val = wdata_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            buf_q   <= '0;
        end else begin
            if (hs) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata[31:0];
                err_q   <= req_err;
            end
            buf_q <= buf_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        buf_d             = buf_q;
        req_ready         = 1'b0;
        resp_valid        = 1'b0;
        resp_rdata        = '0;
        resp_err          = 1'b0;
        dmem_address      = addr_q[ADDR_WIDTH+1:2];
        dmem_write_enable = 1'b0;
        dmem_write_data   = '0;
        dmem_write_data[31:0] = (size_q == SZ_W) ? wdata_q : buf_q;
        unique case (state_q)
            S_IDLE: begin
                req_ready = rst_n;
                if (hs) begin
                    buf_d = '0;
                    if (req_err)
                        state_d = S_DONE;
                    else if (req_we && req_size == SZ_W)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_MERGE;
            end
            S_MERGE: begin
                if (dmem_read_data_valid) begin
                    buf_d   = we_q ? merge_val : load_val;
                    state_d = we_q ? S_WR : S_DONE;
                end
            end
            S_WR: begin
                dmem_write_enable = 1'b1;
                state_d           = S_DONE;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!we_q && !err_q)
                    resp_rdata[31:0] = buf_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu with a registered-read word memory model.
// Expectations are pushed on handshake and checked when resp_valid pulses.
module tb_dmem_lsu;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [AW+1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] dmem_address;
    logic [31:0]   dmem_write_data;
    logic          dmem_write_enable;
    logic [31:0]   dmem_read_data;
    logic          dmem_read_data_valid = 1'b1;

    dmem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_we               (req_we),
        .req_size             (req_size),
        .req_unsigned         (req_unsigned),
        .req_addr             (req_addr),
        .req_wdata            (req_wdata),
        .resp_valid           (resp_valid),
        .resp_rdata           (resp_rdata),
        .resp_err             (resp_err),
        .dmem_address         (dmem_address),
        .dmem_write_data      (dmem_write_data),
        .dmem_write_enable    (dmem_write_enable),
        .dmem_read_data       (dmem_read_data),
        .dmem_read_data_valid (dmem_read_data_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          t;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          wr_cyc = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] rd_q = '0;

    assign dmem_read_data = rd_q;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dmem_write_enable)
            mem[dmem_address] <= dmem_write_data;
        rd_q <= mem[dmem_address];
    end

    always @(negedge clk) begin
        if (dmem_write_enable) begin
            wr_cnt  <= wr_cnt + 1;
            wr_cyc  <= cyc;
            wr_addr <= dmem_address;
        end
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rdata", resp_rdata, e.rdata);
                chk("err", {31'd0, resp_err}, {31'd0, e.err});
                chk("latency", cyc - e.t, e.lat);
            end
        end
    end

    // Returns at the falling edge one cycle after the handshake.
    task automatic issue(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [AW+1:0] a,
                         input logic [31:0] wd, input logic [31:0] erd,
                         input logic eerr, input int lat, input bit push);
        int n;
        exp_t e;
        @(negedge clk);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end else begin
            e.rdata = erd;
            e.err   = eerr;
            e.lat   = lat;
            e.t     = cyc;
            if (push)
                sb_q.push_back(e);
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 30 && sb_q.size() != 0; i++)
            @(negedge clk);
        if (sb_q.size() != 0) begin
            chk("resp_timeout", sb_q.size(), 32'd0);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int t0;
        int w0;
        for (int i = 0; i < (1 << AW); i++)
            mem[i] = 32'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_we", {31'd0, dmem_write_enable}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // sw / lw
        t0 = cyc + 1;
        issue(1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 0, 0, 2, 1);
        wait_done();
        chk("sw_wr_cycle", wr_cyc - t0, 32'd1);
        chk("sw_wr_addr", {22'd0, wr_addr}, 32'h4);
        chk("sw_wr_cnt", wr_cnt, 32'd1);
        chk("mem_sw", mem[4], 32'hDEADBEEF);
        issue(0, 2'b10, 0, 12'h010, 0, 32'hDEADBEEF, 0, 3, 1);
        wait_done();

        // sb / lb / lbu
        issue(1, 2'b00, 0, 12'h013, 32'h000000A5, 0, 0, 4, 1);
        wait_done();
        chk("mem_sb", mem[4], 32'hA5ADBEEF);
        issue(0, 2'b00, 0, 12'h013, 0, 32'hFFFFFFA5, 0, 3, 1);
        issue(0, 2'b00, 1, 12'h013, 0, 32'h000000A5, 0, 3, 1);
        issue(0, 2'b00, 0, 12'h011, 0, 32'hFFFFFFBE, 0, 3, 1);
        wait_done();

        // sh / lh / lhu
        issue(1, 2'b01, 0, 12'h012, 32'hFFFF1234, 0, 0, 4, 1);
        wait_done();
        chk("mem_sh", mem[4], 32'h1234BEEF);
        issue(0, 2'b01, 0, 12'h010, 0, 32'hFFFFBEEF, 0, 3, 1);
        issue(0, 2'b01, 1, 12'h012, 0, 32'h00001234, 0, 3, 1);
        wait_done();

        // Misaligned word load and illegal size
        w0 = wr_cnt;
`ifdef LSU_ALIGN_CHECK_EN
        issue(0, 2'b10, 0, 12'h011, 0, 32'h0, 1, 1, 1);
`else
        issue(0, 2'b10, 0, 12'h011, 0, 32'h1234BEEF, 0, 3, 1);
`endif
        issue(1, 2'b11, 0, 12'h010, 32'h55555555, 32'h0, 1, 1, 1);
        issue(0, 2'b11, 0, 12'h010, 0, 32'h0, 1, 1, 1);
        wait_done();
        chk("err_no_write", wr_cnt, w0);
        chk("mem_after_err", mem[4], 32'h1234BEEF);

        // Read-valid stall plus ignored request while busy
        w0 = wr_cnt;
        issue(0, 2'b00, 0, 12'h010, 0, 32'hFFFFFFEF, 0, 6, 1);
        dmem_read_data_valid = 1'b0;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 12'h000;
        req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy_ready", {31'd0, req_ready}, 32'd0);
        end
        dmem_read_data_valid = 1'b1;
        req_valid = 1'b0;
        wait_done();
        chk("busy_no_write", wr_cnt, w0);
        chk("mem0_untouched", mem[0], 32'h0);

        // Reset during MERGE of a sub-word store
        w0 = wr_cnt;
        issue(1, 2'b00, 0, 12'h010, 32'h00000077, 0, 0, 4, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_we", {31'd0, dmem_write_enable}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        repeat (6) @(negedge clk);
        chk("rst_no_write", wr_cnt, w0);
        chk("mem_after_rst", mem[4], 32'h1234BEEF);

        // Back-to-back after reset still works
        issue(0, 2'b01, 1, 12'h010, 0, 32'h0000BEEF, 0, 3, 1);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit directly upstream of the word-addressed data memory.
- Accepts byte-addressed load/store requests (byte, half, word; signed/unsigned) from the execute stage.
- Translates each request into word accesses on the data memory port. Memory has a 1-cycle registered-address read and word-only writes.
- Sub-word stores are done as read-modify-write. Load data is extracted and sign/zero-extended before return.

Parameters:
DATA_WIDTH, `DATA_WIDTH (32), data word width; byte-lane logic is fixed at 32, other values unsupported.
ADDR_WIDTH, `DMEM_ADDR_WIDTH, word-address width of the data memory.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  LSU can accept a request this cycle.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  in  ADDR_WIDTH+2  byte address.
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  load result; 0 for stores and errors.
resp_err  out  1  with resp_valid: request rejected, no memory access performed.
dmem_address  out  ADDR_WIDTH  word address to memory.
dmem_write_data  out  32  word to write.
dmem_write_enable  out  1  memory write strobe.
dmem_read_data  in  32  memory read word; valid the cycle after an address is presented.
dmem_read_data_valid  in  1  memory read qualifier.

Behaviour:
- States: IDLE, RD, MERGE, WR, DONE. Registered state.
- Request capture:
  - req_ready = 1 only in IDLE and only while rst_n high.
  - Handshake = req_valid & req_ready. On handshake, latch we, size, unsigned, addr, wdata.
  - req_valid in any other state is ignored; the core holds it.
- IDLE transitions on handshake:
  - error → DONE;
  - load → RD;
  - word store → WR;
  - byte/half store → RD.
- RD: dmem_address = latched addr[ADDR_WIDTH+1:2], write enable 0. Unconditionally → MERGE.
- MERGE: dmem_address held.
  - If dmem_read_data_valid = 0, stay in MERGE.
  - Otherwise capture into buf:
    - load: extracted, extended value;
    - store: dmem_read_data with the selected lane replaced by wdata[7:0] or wdata[15:0].
  - Load → DONE; store → WR.
- Byte lanes (little-endian): byte lane = addr[1:0]; half lane = addr[1] (bits [15:0] or [31:16]).
- WR: dmem_address held, dmem_write_data = buf (or latched wdata for word stores), dmem_write_enable = 1 for exactly this cycle. → DONE.
- DONE: resp_valid = 1, resp_rdata = buf for loads, else 0. resp_err set if error. → IDLE. The core always accepts responses; there is no response backpressure.
- dmem_address is driven from the latched address in all states, including IDLE. dmem_write_enable is 0 outside WR.
- Latency from handshake cycle T to resp_valid:
  - load: T+3;
  - word store: T+2;
  - sub-word store: T+4;
  - error: T+1.
  - Each dmem_read_data_valid-low cycle in MERGE adds one cycle.
- Errors: size 11 is always an error (resp_err = 1). Alignment errors are defined under Optional Feature.
- Reset (asynchronous, any state):
  - state → IDLE;
  - buf, latches, resp_rdata, resp_err → 0;
  - resp_valid = 0, dmem_write_enable = 0 immediately.
  - An in-flight store is dropped with no partial write.
  - req_ready rises the first cycle after rst_n deasserts.
- Back-to-back: a new request can be accepted in the cycle after DONE (IDLE). There is no overlap.

Optional Feature:
Macro LSU_ALIGN_CHECK_EN.
- Defined: half at odd address, or word with addr[1:0] ≠ 00, is an error → DONE at T+1 with resp_err = 1, no memory access.
- Undefined: alignment is never checked. Half uses addr[1] and ignores addr[0]. Word ignores addr[1:0]. resp_err is raised only for size 11.

Test Plan:
1. sw 0xDEADBEEF @0x10 → dmem_write_enable high 1 cycle at T+1 with address 0x4; resp_valid at T+2. Then lw @0x10 → resp_rdata 0xDEADBEEF at T+3.
2. sb 0xA5 @0x13 → word 0xA5ADBEEF, resp at T+4. Then lb @0x13 → 0xFFFFFFA5; lbu @0x13 → 0x000000A5.
3. sh 0x1234 @0x12 → word 0x1234BEEF. Then lh @0x10 → 0xFFFFBEEF; lhu @0x12 → 0x00001234.
4. With macro: lw @0x11 → resp_valid T+1, resp_err 1, no write strobe. Without macro: same request → resp_rdata 0x1234BEEF, resp_err 0. size 11 → resp_err 1 in both builds.
5. dmem_read_data_valid held low 3 cycles during MERGE of lb @0x10 → resp at T+6 with 0xFFFFFFEF. A second req_valid during busy is not accepted (req_ready 0).
6. rst_n pulsed low during MERGE of sb @0x10 → no write strobe, word unchanged (0x1234BEEF), resp_valid never asserted. req_ready = 1 one cycle after release.
